// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared definitions for the data-memory arbiter slice.
//   - PORT_CPU / PORT_AUX : requester indices (CPU load/store, loader/debug)
//   - NUM_PORTS           : number of requesters
//   - STG_ADDR_W/DATA_W   : widths of the pipeline stage record; the top-level
//                           ADDR_W/DATA_W parameters default to these and must
//                           stay equal to them
//   - stage_t             : one in-flight request {valid, tag, we, err, addr, wdata}
//   - addr_out_of_range() : address range check against the memory depth
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam logic        PORT_CPU   = 1'b0;
  localparam logic        PORT_AUX   = 1'b1;
  localparam int unsigned NUM_PORTS  = 32'd2;
  localparam int unsigned STG_ADDR_W = 32'd5;
  localparam int unsigned STG_DATA_W = 32'd32;

  typedef struct packed {
    logic                  valid;
    logic                  tag;
    logic                  we;
    logic                  err;
    logic [STG_ADDR_W-1:0] addr;
    logic [STG_DATA_W-1:0] wdata;
  } stage_t;

  // An address at or beyond the populated depth must never reach the memory.
  function automatic logic addr_out_of_range(input logic [STG_ADDR_W-1:0] addr,
                                             input int unsigned           depth);
    logic [31:0] addr_ext;
    addr_ext = 32'(addr);
    return (addr_ext >= 32'(depth));
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
//   Requester-side bundle of the data-memory arbiter, one lane per port.
//   master : used by the requesters (drive req_*, receive req_ready / rsp_*)
//   slave  : used by dmem_arbiter
//   Signals
//     req_valid[i] / req_ready[i]   request handshake (ready is a same-cycle grant)
//     req_we[i], req_addr[i], req_wdata[i]   request payload
//     rsp_valid[i]                  one-cycle response pulse for port i
//     rsp_rdata, rsp_err            response payload, shared by both ports
// ---------------------------------------------------------------------------
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = STG_ADDR_W,
  parameter int unsigned DATA_W = STG_DATA_W
) ();

  logic [NUM_PORTS-1:0]             req_valid;
  logic [NUM_PORTS-1:0]             req_ready;
  logic [NUM_PORTS-1:0]             req_we;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_PORTS-1:0]             rsp_valid;
  logic [DATA_W-1:0]                rsp_rdata;
  logic                             rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-input round-robin picker, purely combinational. The last-grant state
//   lives in the instantiating module.
//   Ports
//     valid[1:0]  in   request present per port
//     last_grant  in   port granted most recently
//     fixed_prio  in   1 = port 0 always wins a tie (last_grant ignored)
//     grant[1:0]  out  one-hot grant, 0 when nothing is requested
//     grant_id    out  index of the granted port (0 when nothing is granted)
// ---------------------------------------------------------------------------
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic [1:0] grant,
  output logic       grant_id
);

  // Pick one requester; on a tie the port that was not served last wins.
  always_comb begin
    grant    = 2'b00;
    grant_id = PORT_CPU;
    case (valid)
      2'b01: begin
        grant    = 2'b01;
        grant_id = PORT_CPU;
      end
      2'b10: begin
        grant    = 2'b10;
        grant_id = PORT_AUX;
      end
      2'b11: begin
        if (fixed_prio || (last_grant == PORT_AUX)) begin
          grant    = 2'b01;
          grant_id = PORT_CPU;
        end else begin
          grant    = 2'b10;
          grant_id = PORT_AUX;
        end
      end
      default: begin
        grant    = 2'b00;
        grant_id = PORT_CPU;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares a single-port data memory between the CPU load/store path (port 0)
//   and a loader/debug port (port 1). Each request is one word read or write.
//   Pipeline: accept (cycle N, combinational grant) -> issue to memory (N+1,
//   registered) -> tagged response (N+2, registered). One accept per cycle,
//   responses in acceptance order, no response backpressure.
//   Ports
//     clk        in   rising-edge clock
//     reset_n    in   asynchronous active-low reset; drops all in-flight work
//     bus        slave modport of dmem_arbiter_if (requests and responses)
//     mem_re     out  memory read enable (registered)
//     mem_we     out  memory write enable (registered)
//     mem_addr   out  memory word address (registered)
//     mem_wdata  out  memory write data (registered)
//     mem_rdata  in   memory read data, combinational from mem_addr/mem_re
//   Configuration macro
//     DMEM_ARB_FIXED_PRIO_EN : port 0 always wins a tie and no last-grant
//                              state exists; undefined selects round-robin.
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = STG_ADDR_W,
  parameter int unsigned DATA_W = STG_DATA_W,
  parameter int unsigned DEPTH  = 32'd32
) (
  input  logic              clk,
  input  logic              reset_n,
  dmem_arbiter_if.slave     bus,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        grant_s;
  logic              grant_id_s;
  logic [1:0]        req_ready_s;
  logic              accept_s;
  logic              last_grant_s;
  logic              fixed_prio_s;

  stage_t            s1_next_s;
  stage_t            s1_r;
  logic              mem_re_r;
  logic              mem_we_r;

  logic [1:0]        rsp_valid_next_s;
  logic [DATA_W-1:0] rsp_rdata_next_s;
  logic              rsp_err_next_s;
  logic [1:0]        rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              rsp_err_r;

  rr_arb2 u_rr_arb2 (
    .valid      (bus.req_valid),
    .last_grant (last_grant_s),
    .fixed_prio (fixed_prio_s),
    .grant      (grant_s),
    .grant_id   (grant_id_s)
  );

  // The grant is masked by reset so that no handshake completes while the
  // pipeline is held in reset.
  assign req_ready_s   = grant_s & {2{reset_n}};
  assign accept_s      = |req_ready_s;
  assign bus.req_ready = req_ready_s;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Fixed priority: no tie history is needed.
  assign last_grant_s = PORT_AUX;
  assign fixed_prio_s = 1'b1;
`else
  logic last_grant_r;

  assign last_grant_s = last_grant_r;
  assign fixed_prio_s = 1'b0;

  // Remember the most recently accepted port; reset value lets port 0 win the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_r <= PORT_AUX;
    end else if (accept_s) begin
      last_grant_r <= grant_id_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

  // Capture the granted request into the stage-1 record (all zero when idle).
  always_comb begin
    s1_next_s = {$bits(stage_t){1'b0}};
    if (accept_s) begin
      s1_next_s.valid = 1'b1;
      s1_next_s.tag   = grant_id_s;
      s1_next_s.we    = bus.req_we[grant_id_s];
      s1_next_s.err   = addr_out_of_range(bus.req_addr[grant_id_s], DEPTH);
      s1_next_s.addr  = bus.req_addr[grant_id_s];
      s1_next_s.wdata = bus.req_wdata[grant_id_s];
    end else begin
      s1_next_s = {$bits(stage_t){1'b0}};
    end
  end

  // Stage-1 (issue) register; enables are suppressed for out-of-range addresses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_r     <= {$bits(stage_t){1'b0}};
      mem_we_r <= 1'b0;
      mem_re_r <= 1'b0;
    end else begin
      s1_r     <= s1_next_s;
      mem_we_r <= s1_next_s.valid &  s1_next_s.we & ~s1_next_s.err;
      mem_re_r <= s1_next_s.valid & ~s1_next_s.we & ~s1_next_s.err;
    end
  end

  assign mem_re    = mem_re_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = s1_r.addr;
  assign mem_wdata = s1_r.wdata;

  // Build the response: read data only for in-range reads, zero otherwise.
  always_comb begin
    rsp_valid_next_s = 2'b00;
    rsp_rdata_next_s = {DATA_W{1'b0}};
    rsp_err_next_s   = 1'b0;
    if (s1_r.valid) begin
      rsp_valid_next_s[s1_r.tag] = 1'b1;
      rsp_err_next_s             = s1_r.err;
      if (!s1_r.we && !s1_r.err) begin
        rsp_rdata_next_s = mem_rdata;
      end else begin
        rsp_rdata_next_s = {DATA_W{1'b0}};
      end
    end else begin
      rsp_valid_next_s = 2'b00;
      rsp_rdata_next_s = {DATA_W{1'b0}};
      rsp_err_next_s   = 1'b0;
    end
  end

  // Stage-2 (response) register; rsp_valid is a single-cycle pulse per request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_r <= 2'b00;
      rsp_rdata_r <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_next_s;
      rsp_rdata_r <= rsp_rdata_next_s;
      rsp_err_r   <= rsp_err_next_s;
    end
  end

  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter (DEPTH=16 so addresses 16..31 are out of range).
// A reference model predicts grants and responses from the arbitration and
// memory rules; expected issue/response records go into queues that a
// separate monitor drains whenever the DUT presents outputs.
module tb_dmem_arbiter;

  localparam int unsigned TB_DEPTH = 16;

  typedef struct {
    int          cyc;
    logic        tag;
    logic [31:0] rdata;
    logic        err;
  } rsp_exp_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic        re;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } iss_exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_re, mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  dmem_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .DEPTH(TB_DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory seen by the DUT
  logic [31:0] mem_a [32];
  assign mem_rdata = mem_re ? mem_a[mem_addr] : 32'd0;

  initial begin
    for (int i = 0; i < 32; i++) mem_a[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    forever begin
      @(posedge clk);
      if (mem_we) mem_a[mem_addr] = mem_wdata;
    end
  end

  // Reference model state
  logic [31:0] model_mem [32];
  logic        model_last;
  rsp_exp_t    rq[$];
  iss_exp_t    iq[$];

  // Pending requests per port (held until the model says they were accepted)
  logic [1:0]  p_v, p_we;
  logic [4:0]  p_addr [2];
  logic [31:0] p_wd   [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] model_pick(input logic [1:0] v);
    if (v == 2'b01) return 2'b01;
    if (v == 2'b10) return 2'b10;
    if (v == 2'b11) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      return 2'b01;
`else
      return model_last ? 2'b01 : 2'b10;
`endif
    end
    return 2'b00;
  endfunction

  task automatic model_accept(input logic g);
    rsp_exp_t r;
    iss_exp_t s;
    logic     err;
    err     = (int'(p_addr[g]) >= int'(TB_DEPTH));
    r.cyc   = cyc + 2;
    r.tag   = g;
    r.err   = err;
    r.rdata = (!p_we[g] && !err) ? model_mem[p_addr[g]] : 32'd0;
    rq.push_back(r);
    s.cyc   = cyc + 1;
    s.we    = p_we[g] & ~err;
    s.re    = ~p_we[g] & ~err;
    s.addr  = p_addr[g];
    s.wdata = p_wd[g];
    iq.push_back(s);
    if (p_we[g] && !err) model_mem[p_addr[g]] = p_wd[g];
    model_last = g;
  endtask

  task automatic drive();
    bus.req_valid    = p_v;
    bus.req_we       = p_we;
    bus.req_addr[0]  = p_addr[0];
    bus.req_addr[1]  = p_addr[1];
    bus.req_wdata[0] = p_wd[0];
    bus.req_wdata[1] = p_wd[1];
  endtask

  // One cycle: drive after the falling edge, check the grant, advance the model.
  task automatic tick();
    logic [1:0] exp_g;
    drive();
    #1;
    exp_g = model_pick(p_v);
    chk("req_ready", bus.req_ready, exp_g);
    if (exp_g != 2'b00) begin
      model_accept(exp_g[1]);
      p_v[exp_g[1]] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic load(input int port, input logic we, input logic [4:0] addr, input logic [31:0] wd);
    p_v[port]    = 1'b1;
    p_we[port]   = we;
    p_addr[port] = addr;
    p_wd[port]   = wd;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ready"}, bus.req_ready, 2'b00);
    chk({name, "_rsp"}, {bus.rsp_valid, bus.rsp_err}, 3'b000);
    chk({name, "_rdata"}, bus.rsp_rdata, 32'd0);
    chk({name, "_mem_en"}, {mem_re, mem_we}, 2'b00);
    chk({name, "_mem_bus"}, {mem_addr, mem_wdata}, 37'd0);
  endtask

  // Monitor: compare memory-side issue and responses against the queues.
  initial begin
    iss_exp_t s;
    rsp_exp_t r;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (iq.size() > 0 && iq[0].cyc <= cyc) begin
          s = iq.pop_front();
          chk("issue_cycle", cyc, s.cyc);
          chk("mem_we", mem_we, s.we);
          chk("mem_re", mem_re, s.re);
          chk("mem_addr", mem_addr, s.addr);
          if (s.we) chk("mem_wdata", mem_wdata, s.wdata);
        end else begin
          chk("mem_idle", {mem_we, mem_re}, 2'b00);
        end
        if (bus.rsp_valid != 2'b00) begin
          if (rq.size() == 0) begin
            chk("rsp_unexpected", bus.rsp_valid, 2'b00);
          end else begin
            r = rq.pop_front();
            chk("rsp_cycle", cyc, r.cyc);
            chk("rsp_tag", bus.rsp_valid, r.tag ? 2'b10 : 2'b01);
            chk("rsp_rdata", bus.rsp_rdata, r.rdata);
            chk("rsp_err", bus.rsp_err, r.err);
          end
        end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
          r = rq.pop_front();
          chk("rsp_missing", bus.rsp_valid, r.tag ? 2'b10 : 2'b01);
        end
      end
    end
  end

  initial begin
    logic [31:0] saved;
    for (int i = 0; i < 32; i++) model_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    model_last = 1'b1;
    p_v = 2'b00; p_we = 2'b00;
    p_addr[0] = 5'd0; p_addr[1] = 5'd0; p_wd[0] = 32'd0; p_wd[1] = 32'd0;

    // Reset held with both ports requesting: everything stays at zero
    reset_n = 1'b0;
    load(0, 1'b0, 5'd1, 32'd0);
    load(1, 1'b0, 5'd2, 32'd0);
    drive();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();                       // port 0 wins the first tie
    tick();                       // port 1 left alone
    idle(3);

    // Write then read-after-write on port 0
    load(0, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    load(0, 1'b0, 5'd5, 32'd0);
    tick();
    idle(3);

    // Both ports hold reads: arbitration alternates (or port 0 only when fixed)
    for (int k = 0; k < 6; k++) begin
      if (!p_v[0]) load(0, 1'b0, 5'($urandom_range(0, 15)), $urandom);
      if (!p_v[1]) load(1, 1'b0, 5'($urandom_range(0, 15)), $urandom);
      tick();
    end
    p_v = 2'b00;
    idle(3);

    // Out-of-range read on port 1
    load(1, 1'b0, 5'h1F, 32'd0);
    tick();
    idle(3);

    // Reset during the issue cycle of a write
    saved = model_mem[7];
    load(0, 1'b1, 5'd7, 32'hA5A5_0F0F);
    tick();
    #1;
    chk("t5_we_before_reset", mem_we, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("t5_we_async_drop", mem_we, 1'b0);
    chk_all_zero("t5_in_reset");
    rq.delete();
    iq.delete();
    model_mem[7] = saved;
    model_last   = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    chk("t5_mem_unchanged", mem_a[7], saved);
    idle(4);

    // Port 1 streams four writes while port 0 is idle
    for (int k = 0; k < 4; k++) begin
      load(1, 1'b1, 5'(k), $urandom);
      tick();
    end
    idle(3);

    // Randomised traffic, mixing in-range and out-of-range addresses
    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!p_v[p] && ($urandom_range(0, 3) != 0))
          load(p, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)), $urandom);
      end
      tick();
    end
    p_v = 2'b00;
    idle(5);

    chk("drain_rsp", rq.size(), 0);
    chk("drain_iss", iq.size(), 0);
    for (int i = 0; i < 32; i++) chk("mem_final", mem_a[i], model_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
